// File: rtl/wave_classifier_if.sv
// wave_classifier_if: sample stream into the classifier and classification results out of it
interface wave_classifier_if #(
  parameter int PW = 6
);
  logic          sample_valid;
  logic [4:0]    sample;
  logic [1:0]    wave_type;
  logic [PW-1:0] period;
  logic          locked;
  logic          err;
  logic [7:0]    err_cnt;
  modport master (output sample_valid, sample, input wave_type, period, locked, err, err_cnt);
  modport slave  (input sample_valid, sample, output wave_type, period, locked, err, err_cnt);
endinterface

// File: rtl/wave_classifier.sv
// wave_classifier: classifies a 5-bit sample stream as square/sawtooth/triangle and locks on its period; lock-loss counter built only with WAVE_CLASSIFIER_ERR_CNT_EN
module wave_classifier #(
  parameter int MAX_LEVEL = 20,
  parameter int PW = 6
) (
  input logic clk,
  input logic rst,
  wave_classifier_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ACQ, MEAS, CONF, LOCK} state_t;
  localparam logic [4:0] TOP = 5'(MAX_LEVEL);
  localparam logic [PW-1:0] ONE = PW'(1);
  localparam logic [PW-1:0] CMAX = '1;
  state_t state, ns;
  logic [4:0] s, p;
  logic v;
  logic [2:0] mask, compat, nmask;
  logic [PW-1:0] cnt, cnt_nx, p1, period_d;
  logic last_dn, hold, up, dn, jup, jdn, marker, sat, mask_rst, err_d, locked_d;
  logic [1:0] type_d;
  assign s = bus.sample;
  assign v = bus.sample_valid;
  // delta class of the new sample against the previous one; 6-bit compares keep 0/31 from wrapping
  assign hold = s == p;
  assign up = {1'b0, s} == {1'b0, p} + 6'd1;
  assign dn = {1'b0, s} + 6'd1 == {1'b0, p};
  assign jup = p == 5'd0 && s == TOP;
  assign jdn = p == TOP && s == 5'd0;
  // compatible types {sq, saw, tri} for this delta; BAD yields 000
  assign compat = {hold | jup | jdn, up | jdn, up | dn};
  assign nmask = mask & compat;
  // a marker needs the narrowed mask to be one-hot, so an incompatible delta can never be a marker
  assign marker = $onehot(nmask) && (nmask[2] && jup || nmask[1] && jdn || nmask[0] && up && last_dn);
  assign cnt_nx = marker ? ONE : cnt == CMAX ? CMAX : cnt + ONE;
  assign sat = cnt_nx == CMAX;
  assign mask_rst = nmask == 3'b000 || (ns == ACQ && state != ACQ);
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= ns;
  end
  // next state: only valid samples advance; mask collapse or counter saturation drops back to ACQ
  always_comb begin
    ns = state;
    if (v) begin
      if (state == IDLE) ns = ACQ;
      else if (nmask == 3'b000 || (sat && state != ACQ)) ns = ACQ;
      else if (marker) ns = state == ACQ ? MEAS : state == MEAS ? CONF : cnt == p1 ? LOCK : state == CONF ? CONF : ACQ;
    end
  end
  // output values to register; the type comes from the one-hot mask on the locking sample
  always_comb begin
    locked_d = ns == LOCK;
    type_d = !locked_d ? 2'd3 : nmask[2] ? 2'd0 : nmask[1] ? 2'd1 : 2'd2;
    period_d = locked_d ? p1 : '0;
    err_d = v && state == LOCK && ns != LOCK;
  end
  // sample history, mask, period counter and reference period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p <= '0;
      mask <= 3'b111;
      cnt <= '0;
      p1 <= '0;
      last_dn <= 1'b0;
    end else if (v) begin
      p <= s;
      mask <= mask_rst ? 3'b111 : nmask;
      if (state != IDLE) begin
        cnt <= cnt_nx;
        p1 <= marker && ns == CONF ? cnt : p1;
        last_dn <= hold ? last_dn : dn;
      end
    end
  end
  // registered outputs; err is a single-cycle pulse even if the next cycle carries no sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wave_type <= 2'd3;
      bus.period <= '0;
      bus.locked <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      bus.err <= err_d;
      if (v) begin
        bus.wave_type <= type_d;
        bus.period <= period_d;
        bus.locked <= locked_d;
      end
    end
  end
`ifdef WAVE_CLASSIFIER_ERR_CNT_EN
  logic [7:0] ec;
  // saturating count of lock losses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ec <= '0;
    else if (err_d && ec != 8'hff) ec <= ec + 8'd1;
  end
  assign bus.err_cnt = ec;
`else
  assign bus.err_cnt = '0;
`endif
endmodule

// File: tb/tb_wave_classifier.sv
// tb_wave_classifier: directed square/sawtooth/triangle/fault/gap/reset scenarios against a scoreboard of expected results per valid-sample index
module tb_wave_classifier;
  localparam int PW = 6;
  typedef struct {
    int seq;
    logic [1:0] wt;
    logic [PW-1:0] per;
    logic lk;
    logic er;
    logic [7:0] ec;
  } exp_t;
`ifdef WAVE_CLASSIFIER_ERR_CNT_EN
  localparam logic [7:0] EC1 = 8'd1;
`else
  localparam logic [7:0] EC1 = 8'd0;
`endif
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;
  int seq = 0;
  int err_seen = 0;
  exp_t q[$];
  string tq[$];
  always #5 clk = ~clk;
  wave_classifier_if #(.PW(PW)) bus();
  wave_classifier #(.MAX_LEVEL(20), .PW(PW)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
  function automatic logic [4:0] sq_val(input int i);
    return (i % 20) < 10 ? 5'd20 : 5'd0;
  endfunction
  function automatic logic [4:0] saw_val(input int i);
    return 5'(i % 21);
  endfunction
  function automatic logic [4:0] tri_val(input int i);
    int m;
    m = i % 40;
    return m <= 20 ? 5'(m) : 5'(40 - m);
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic exp_push(input string tag, input int sq, input logic [1:0] wt, input int per, input logic lk, input logic er, input logic [7:0] ec);
    exp_t e;
    e.seq = sq;
    e.wt = wt;
    e.per = PW'(per);
    e.lk = lk;
    e.er = er;
    e.ec = ec;
    q.push_back(e);
    tq.push_back(tag);
  endtask
  task automatic drive(input logic v, input logic [4:0] s);
    exp_t e;
    string t;
    bus.sample_valid = v;
    bus.sample = s;
    @(posedge clk);
    #1;
    if (v) seq++;
    if (bus.err) err_seen++;
    while (q.size() > 0 && q[0].seq == seq) begin
      e = q.pop_front();
      t = tq.pop_front();
      check({t, ".wave_type"}, bus.wave_type, e.wt);
      check({t, ".period"}, bus.period, e.per);
      check({t, ".locked"}, bus.locked, e.lk);
      check({t, ".err"}, bus.err, e.er);
      check({t, ".err_cnt"}, bus.err_cnt, e.ec);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    seq = 0;
    err_seen = 0;
  endtask
  initial begin
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.wave_type", bus.wave_type, 2'd3);
    check("reset.period", bus.period, 0);
    check("reset.locked", bus.locked, 1'b0);
    check("reset.err", bus.err, 1'b0);
    check("reset.err_cnt", bus.err_cnt, 8'd0);
    rst = 1'b0;
    // square: 10x20 then 10x0, JUP markers at samples 21, 41, 61
    exp_push("sq_pre", 60, 2'd3, 0, 1'b0, 1'b0, 8'd0);
    exp_push("sq_lock", 61, 2'd0, 20, 1'b1, 1'b0, 8'd0);
    exp_push("sq_hold", 80, 2'd0, 20, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 80; i++) drive(1'b1, sq_val(i));
    check("sq_no_err", err_seen, 0);
    do_reset();
    // sawtooth locks at sample 64; sample 68 (value 4) is faulted to 7, relock at 127
    exp_push("saw_pre", 63, 2'd3, 0, 1'b0, 1'b0, 8'd0);
    exp_push("saw_lock", 64, 2'd1, 21, 1'b1, 1'b0, 8'd0);
    exp_push("saw_hold", 67, 2'd1, 21, 1'b1, 1'b0, 8'd0);
    exp_push("fault", 68, 2'd3, 0, 1'b0, 1'b1, EC1);
    exp_push("fault_after", 69, 2'd3, 0, 1'b0, 1'b0, EC1);
    exp_push("relock_pre", 126, 2'd3, 0, 1'b0, 1'b0, EC1);
    exp_push("relock", 127, 2'd1, 21, 1'b1, 1'b0, EC1);
    exp_push("relock_hold", 130, 2'd1, 21, 1'b1, 1'b0, EC1);
    for (int i = 0; i < 130; i++) drive(1'b1, i == 67 ? 5'd7 : saw_val(i));
    check("fault_one_err", err_seen, 1);
    // reset asserted mid-stream while locked
    bus.sample_valid = 1'b1;
    bus.sample = saw_val(130);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid.wave_type", bus.wave_type, 2'd3);
    check("rst_mid.period", bus.period, 0);
    check("rst_mid.locked", bus.locked, 1'b0);
    check("rst_mid.err", bus.err, 1'b0);
    check("rst_mid.err_cnt", bus.err_cnt, 8'd0);
    rst = 1'b0;
    seq = 0;
    err_seen = 0;
    // triangle: valleys at samples 42, 82, 122
    exp_push("tri_pre", 121, 2'd3, 0, 1'b0, 1'b0, 8'd0);
    exp_push("tri_lock", 122, 2'd2, 40, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 125; i++) drive(1'b1, tri_val(i));
    check("tri_no_err", err_seen, 0);
    do_reset();
    // sawtooth with an idle cycle carrying junk before every valid sample
    exp_push("gap_pre", 63, 2'd3, 0, 1'b0, 1'b0, 8'd0);
    exp_push("gap_lock", 64, 2'd1, 21, 1'b1, 1'b0, 8'd0);
    exp_push("gap_hold", 70, 2'd1, 21, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 70; i++) begin
      drive(1'b0, 5'd31);
      drive(1'b1, saw_val(i));
    end
    drive(1'b0, 5'd9);
    check("gap_idle.locked", bus.locked, 1'b1);
    check("gap_idle.period", bus.period, 21);
    check("gap_no_err", err_seen, 0);
    check("scoreboard_drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wave_classifier.md
# wave_classifier

Receive-side companion to the team's 5-bit signal generator. It watches a stream of 5-bit samples and classifies the waveform as square, sawtooth or triangle. It measures the waveform period in valid samples and asserts lock once two consecutive periods match. It sits downstream of the generator, or of any source of the same sample format, for self-check and monitoring.

## Interface
Parameters:
- MAX_LEVEL, default 20: top sample level of all waveforms; must be 2..31.
- PW, default 6: width of the period counter and of the `period` output.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous and active-high. One clock domain only.
- sample_valid  in  1  qualifies `sample` for the current cycle.
- sample  in  5  waveform sample.
- wave_type  out  2  0 = square, 1 = sawtooth, 2 = triangle, 3 = unknown.
- period  out  PW  locked period in valid samples; 0 when not locked.
- locked  out  1  high while the classification is locked.
- err  out  1  one-cycle pulse when lock is lost.
- err_cnt  out  8  lock-loss counter (see Configuration).

## Operation
Cycles with `sample_valid` low are ignored entirely: no state, counter or output changes.

**Delta class.** Each valid sample `s` is compared with the previous valid sample `p`:
- HOLD: s == p. Compatible types: {sq}.
- UP: s == p+1. Compatible types: {saw, tri}.
- DN: s == p-1. Compatible types: {tri}.
- JUP: p == 0 and s == MAX_LEVEL. Compatible types: {sq}.
- JDN: p == MAX_LEVEL and s == 0. Compatible types: {sq, saw}.
- Any other pair is BAD, compatible with no type.

**Compatibility mask.**
- A 3-bit mask {sq, saw, tri} is set to 111 when ACQ is entered.
- Each delta ANDs its compatible set into the mask.
- When the mask reaches 000, the block returns to ACQ with the mask reset to 111. The current sample is kept as `p`.

**Markers.** Markers are defined only once the mask is one-hot:
- sq: a JUP delta.
- saw: a JDN delta.
- tri: a valley, i.e. an UP delta whose most recent non-HOLD delta was DN.

**Period counter.**
- Loads 1 on a marker sample and increments on every other valid sample.
- Saturates at 2^PW-1. Reaching saturation forces ACQ.

**State machine.**
- IDLE → ACQ on the first valid sample, which only loads `p`.
- ACQ → MEAS on the first marker with a one-hot mask.
- MEAS → CONF on the next marker; the counter value is stored as P1.
- CONF, on each marker: if count == P1, go to LOCK; otherwise P1 = count and stay in CONF.
- LOCK, on each marker: if count == P1, stay in LOCK; on a mismatch go to ACQ.
- Any state with a one-hot mask goes to ACQ on an incompatible delta.
- Leaving LOCK for any reason pulses `err` for one cycle.

## Timing
- Reset values: wave_type = 3, period = 0, locked = 0, err = 0, err_cnt = 0. State is IDLE and the mask is 111.
- All outputs are registered and update on the clock edge that samples the deciding valid sample, one cycle of latency.
- Entering LOCK sets, on the same edge: locked = 1, wave_type = the one-hot mask type, period = P1.
- Leaving LOCK sets, on the same edge: locked = 0, wave_type = 3, period = 0, err = 1.
- While not locked, wave_type = 3.
- An incompatible sample arriving on the same cycle as a marker counts as an incompatible delta; it is not treated as a marker.
- Asserting `rst` mid-stream returns every register to its reset value immediately. Reacquisition starts from IDLE.

## Configuration
- `WAVE_CLASSIFIER_ERR_CNT_EN` defined: `err_cnt` increments once per `err` pulse and saturates at 255. Reset clears it.
- Macro undefined: `err_cnt` is tied to 0 and no counter logic is built.

## Test plan
- Reset check: assert `rst` mid-stream while locked on a sawtooth → next cycle wave_type = 3, period = 0, locked = 0, err = 0.
- Square wave: repeat 10×20 then 10×0 for 4 periods, valid every cycle → locked = 1 with wave_type = 0 and period = 20 by the third JUP. No `err` pulse.
- Sawtooth: repeat 0,1,…,20 → wave_type = 1, period = 21, locked within 3 wraps.
- Triangle: repeat 0,1,…,20,19,…,1 → wave_type = 2, period = 40, locked at the third valley.
- Fault: in a locked sawtooth, replace sample 4 with 7 → locked = 0, wave_type = 3, err pulses once, err_cnt = 1 (macro on). The block relocks to type 1, period 21 within 3 wraps.
- Valid gaps: sawtooth with `sample_valid` low every other cycle → same results as the sawtooth case, period = 21 (only valid samples are counted).
